// File: rtl/atom_result_buffer.sv
// Result FIFO behind the stateful atom: captures {tag, old, new} and hands it on over valid/ready.
// Optional drop counter is enabled by defining ATOM_RESULT_BUF_DROP_CNT_EN.
module atom_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int AFULL_FREE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_pkt_id,
    input  logic [31:0] in_read,
    input  logic [31:0] in_write,
    output logic        in_stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pkt_id,
    output logic [31:0] out_old,
    output logic [31:0] out_new,
    output logic        out_updated,
    output logic [15:0] drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_FREE);

    typedef struct packed {
        logic [15:0] pkt_id;
        logic [31:0] old_val;
        logic [31:0] new_val;
        logic        updated;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = in_valid & ((count < DEPTH_C) | pop);
    // Depends on registered occupancy only, so the issuer sees a clean early hint.
    assign in_stall  = ((DEPTH_C - count) <= AFULL_C);

    // Storage is never reset; stale contents are hidden behind out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr].pkt_id  <= in_pkt_id;
            mem[wr_ptr].old_val <= in_read;
            mem[wr_ptr].new_val <= in_write;
            mem[wr_ptr].updated <= (in_read != in_write);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_comb begin
        head = '0;
        if (out_valid) head = mem[rd_ptr];
    end

    assign out_pkt_id  = head.pkt_id;
    assign out_old     = head.old_val;
    assign out_new     = head.new_val;
    assign out_updated = head.updated;

`ifdef ATOM_RESULT_BUF_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_q;

    assign drop = in_valid & ~push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'h0000;
`endif
endmodule

// File: tb/tb_atom_result_buffer.sv
// Directed bench for atom_result_buffer at DEPTH 4, AFULL_FREE 1.
module tb_atom_result_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_pkt_id;
    logic [31:0] in_read;
    logic [31:0] in_write;
    logic        in_stall;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pkt_id;
    logic [31:0] out_old;
    logic [31:0] out_new;
    logic        out_updated;
    logic [15:0] drop_count;

    int total  = 0;
    int failed = 0;

`ifdef ATOM_RESULT_BUF_DROP_CNT_EN
    localparam logic [15:0] ONE_DROP = 16'd1;
    localparam logic [15:0] SAT_DROP = 16'hFFFF;
`else
    localparam logic [15:0] ONE_DROP = 16'd0;
    localparam logic [15:0] SAT_DROP = 16'd0;
`endif

    atom_result_buffer #(.DEPTH(4), .AFULL_FREE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_pkt_id(in_pkt_id), .in_read(in_read), .in_write(in_write),
        .in_stall(in_stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_pkt_id(out_pkt_id),
        .out_old(out_old), .out_new(out_new), .out_updated(out_updated),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] id, input logic [31:0] rd, input logic [31:0] wr);
        in_valid  = v;
        in_pkt_id = id;
        in_read   = rd;
        in_write  = wr;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 16'hBEEF, 32'd1, 32'd2);

        // Reset held 2 cycles with in_valid high
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_stall", {31'b0, in_stall}, 32'd0);
        check("rst_drop_count", {16'b0, drop_count}, 32'd0);
        check("rst_out_pkt_id", {16'b0, out_pkt_id}, 32'd0);
        check("rst_out_old", out_old, 32'd0);

        // Single result, no same-cycle bypass
        drive(1'b1, 16'h0001, 32'd5, 32'd7);
        check("single_no_bypass", {31'b0, out_valid}, 32'd0);
        tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_id", {16'b0, out_pkt_id}, 32'h0001);
        check("single_old", out_old, 32'd5);
        check("single_new", out_new, 32'd7);
        check("single_updated", {31'b0, out_updated}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_popped", {31'b0, out_valid}, 32'd0);

        drive(1'b1, 16'h0002, 32'd9, 32'd9);
        tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        check("same_old", out_old, 32'd9);
        check("same_updated", {31'b0, out_updated}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("same_popped", {31'b0, out_valid}, 32'd0);

        // Fill and stall
        drive(1'b1, 16'd1, 32'd10, 32'd11); tick();
        check("fill1_stall", {31'b0, in_stall}, 32'd0);
        drive(1'b1, 16'd2, 32'd20, 32'd21); tick();
        check("fill2_stall", {31'b0, in_stall}, 32'd0);
        drive(1'b1, 16'd3, 32'd30, 32'd31); tick();
        check("fill3_stall", {31'b0, in_stall}, 32'd1);
        drive(1'b1, 16'd4, 32'd40, 32'd41); tick();
        check("fill4_stall", {31'b0, in_stall}, 32'd1);
        check("fill4_drop", {16'b0, drop_count}, 32'd0);
        drive(1'b1, 16'd5, 32'd50, 32'd51); tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        check("fill5_drop", {16'b0, drop_count}, {16'b0, ONE_DROP});
        check("fill5_head", {16'b0, out_pkt_id}, 32'd1);
        check("fill5_old", out_old, 32'd10);

        // Full with simultaneous push and pop
        drive(1'b1, 16'd6, 32'd60, 32'd60);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        out_ready = 1'b0;
        check("pp_head", {16'b0, out_pkt_id}, 32'd2);
        check("pp_drop", {16'b0, drop_count}, {16'b0, ONE_DROP});
        check("pp_stall", {31'b0, in_stall}, 32'd1);
        // Drain: exactly 4 entries in order 2,3,4,6
        out_ready = 1'b1;
        check("drain_id0", {16'b0, out_pkt_id}, 32'd2);
        tick(); check("drain_id1", {16'b0, out_pkt_id}, 32'd3);
        check("drain_stall1", {31'b0, in_stall}, 32'd1);
        tick(); check("drain_id2", {16'b0, out_pkt_id}, 32'd4);
        check("drain_stall2", {31'b0, in_stall}, 32'd0);
        tick(); check("drain_id3", {16'b0, out_pkt_id}, 32'd6);
        check("drain_upd3", {31'b0, out_updated}, 32'd0);
        tick(); check("drain_empty", {31'b0, out_valid}, 32'd0);

        // Pointer wrap: streaming, occupancy stays at 1
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 16'(i), 32'(i * 3), 32'(i * 3 + 1));
            tick();
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_id", {16'b0, out_pkt_id}, 32'(i));
            check("stream_new", out_new, 32'(i * 3 + 1));
            check("stream_stall", {31'b0, in_stall}, 32'd0);
        end
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        tick();
        out_ready = 1'b0;
        check("stream_empty", {31'b0, out_valid}, 32'd0);
        check("stream_drop", {16'b0, drop_count}, {16'b0, ONE_DROP});

        // Mid-operation reset with 3 entries queued
        drive(1'b1, 16'h21, 32'd1, 32'd2); tick();
        drive(1'b1, 16'h22, 32'd1, 32'd2); tick();
        drive(1'b1, 16'h23, 32'd1, 32'd2); tick();
        check("pre_rst_stall", {31'b0, in_stall}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_id", {16'b0, out_pkt_id}, 32'd0);
        check("mid_rst_stall", {31'b0, in_stall}, 32'd0);
        check("mid_rst_drop", {16'b0, drop_count}, 32'd0);
        tick();
        check("mid_rst_valid2", {31'b0, out_valid}, 32'd0);
        drive(1'b1, 16'h30, 32'd4, 32'd8); tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        check("post_rst_head", {16'b0, out_pkt_id}, 32'h30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_rst_empty", {31'b0, out_valid}, 32'd0);

        // Saturation: fill 4, then 65537 drops
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h40 + i), 32'd0, 32'd1);
            tick();
        end
        check("sat_no_drop_yet", {16'b0, drop_count}, 32'd0);
        for (int i = 0; i < 65535; i++) tick();
        check("sat_at_ffff", {16'b0, drop_count}, {16'b0, SAT_DROP});
        tick();
        tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0);
        check("sat_hold", {16'b0, drop_count}, {16'b0, SAT_DROP});
        check("sat_head", {16'b0, out_pkt_id}, 32'h40);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
